// File: rtl/minority_pattern_gen_if.sv
// Purpose: handshake/bus bundle for minority_pattern_gen.
//   REQ/TARGET start a run, READY is the consumer's acceptance,
//   VEC/VALID/LAST present candidates, BUSY/DONE/COUNT report run status.
// Modports: master = requester/consumer side, slave = generator side.
interface minority_pattern_gen_if;
    logic       REQ;
    logic       TARGET;
    logic       READY;
    logic [3:0] VEC;
    logic       VALID;
    logic       LAST;
    logic       BUSY;
    logic       DONE;
    logic [3:0] COUNT;

    modport master (
        output REQ, TARGET, READY,
        input  VEC, VALID, LAST, BUSY, DONE, COUNT
    );

    modport slave (
        input  REQ, TARGET, READY,
        output VEC, VALID, LAST, BUSY, DONE, COUNT
    );
endinterface

// File: rtl/minority_pattern_gen.sv
// Purpose: walks 4-bit candidates in ascending order and emits, under a
//   VALID/READY handshake, every vector whose 4-input minority equals the
//   target captured at run start (5 vectors for target 1, 11 for target 0).
// Ports:
//   CLK  - clock, all state on rising edge
//   RST  - synchronous active-high reset
//   bus  - slave side of minority_pattern_gen_if
//          in : REQ, TARGET, READY
//          out: VEC, VALID, LAST (combinational decode), BUSY, DONE, COUNT
module minority_pattern_gen (
    input  logic                    CLK,
    input  logic                    RST,
    minority_pattern_gen_if.slave   bus
);

    localparam int unsigned VEC_W = 4;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   cand_q, cand_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               tgt_q, tgt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cand_match_c;
    logic               last_c;
    logic [VEC_W-1:0]   last_pat_c;

    // minority of 4 inputs: at most one bit set (v & (v-1) clears the lowest set bit)
    function automatic logic minority4(input logic [VEC_W-1:0] v);
        return ((v & (v - VEC_W'(1))) == '0);
    endfunction

    // Candidate test and final-vector decode
    always_comb begin
        cand_match_c = (minority4(cand_q) == tgt_q);
        last_pat_c   = tgt_q ? VEC_W'(4'b1000) : VEC_W'(4'b1111);
        last_c       = valid_q & (vec_q == last_pat_c);
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.REQ)      state_d = ST_SCAN;
            ST_SCAN: if (cand_match_c) state_d = ST_EMIT;
            ST_EMIT: if (bus.READY)    state_d = last_c ? ST_FIN : ST_SCAN;
            ST_FIN:                    state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        cand_d  = cand_q;
        vec_d   = vec_q;
        tgt_d   = tgt_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.REQ) begin
                    tgt_d   = bus.TARGET;
                    cand_d  = '0;
                    count_d = '0;
                end
            end
            ST_SCAN: begin
                if (cand_match_c) begin
                    vec_d = cand_q;
                end else begin
                    cand_d = cand_q + VEC_W'(1);
                end
            end
            ST_EMIT: begin
                if (bus.READY) begin
                    count_d = count_q + CNT_W'(1);
                    // the final vector never advances, so CAND cannot wrap
                    if (!last_c) begin
                        cand_d = cand_q + VEC_W'(1);
                    end
                end
            end
            default: ;
        endcase
        // status flags registered from the upcoming state
        valid_d = (state_d == ST_EMIT);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_FIN);
    end

    // Datapath / output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            cand_q  <= '0;
            vec_q   <= '0;
            tgt_q   <= 1'b0;
            count_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            vec_q   <= vec_d;
            tgt_q   <= tgt_d;
            count_q <= count_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.VEC   = vec_q;
    assign bus.VALID = valid_q;
    assign bus.LAST  = last_c;
    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
    assign bus.COUNT = count_q;

endmodule

// File: tb/tb_minority_pattern_gen.sv
// Directed bench for minority_pattern_gen; outputs sampled 1 time unit
// after each rising edge, inputs driven right after that sample.
module tb_minority_pattern_gen;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    minority_pattern_gen_if bus ();

    minority_pattern_gen dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] exp_t1 [0:4]  = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8};
    logic [3:0] exp_t0 [0:10] = '{4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA,
                                  4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.REQ = 1'b0; bus.TARGET = 1'b0; bus.READY = 1'b1;
        tick(); tick();
        rst = 1'b0;
        vectors++; if (bus.VEC !== 4'h0)   begin miscompares++; $display("FAIL reset_vec got=%h exp=0", bus.VEC); end
        vectors++; if (bus.VALID !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", bus.VALID); end
        vectors++; if (bus.LAST !== 1'b0)  begin miscompares++; $display("FAIL reset_last got=%b exp=0", bus.LAST); end
        vectors++; if (bus.BUSY !== 1'b0)  begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
        vectors++; if (bus.DONE !== 1'b0)  begin miscompares++; $display("FAIL reset_done got=%b exp=0", bus.DONE); end
        vectors++; if (bus.COUNT !== 4'h0) begin miscompares++; $display("FAIL reset_count got=%h exp=0", bus.COUNT); end
    endtask

    // Full run with READY held high; optionally pokes REQ/TARGET=0 mid-run.
    task automatic test_run(input logic target, input int n, input bit poke_req, input string tag);
        logic [3:0] exp_v;
        int         waitc;
        bus.READY = 1'b1; bus.TARGET = target; bus.REQ = 1'b1;
        tick();
        bus.REQ = 1'b0; bus.TARGET = ~target;
        vectors++; if (bus.BUSY !== 1'b1) begin miscompares++; $display("FAIL %s_busy got=%b exp=1", tag, bus.BUSY); end
        for (int i = 0; i < n; i++) begin
            waitc = 0;
            while (bus.VALID !== 1'b1 && waitc < 8) begin tick(); waitc++; end
            exp_v = target ? exp_t1[i] : exp_t0[i];
            vectors++; if (bus.VALID !== 1'b1) begin miscompares++; $display("FAIL %s_valid_timeout idx=%0d got=%b exp=1", tag, i, bus.VALID); end
            vectors++; if (bus.VEC !== exp_v) begin miscompares++; $display("FAIL %s_vec idx=%0d got=%h exp=%h", tag, i, bus.VEC, exp_v); end
            vectors++; if (bus.LAST !== (i == n - 1)) begin miscompares++; $display("FAIL %s_last idx=%0d got=%b exp=%b", tag, i, bus.LAST, (i == n - 1)); end
            vectors++; if (bus.COUNT !== 4'(i)) begin miscompares++; $display("FAIL %s_count idx=%0d got=%h exp=%h", tag, i, bus.COUNT, 4'(i)); end
            if (poke_req && (i == 1 || i == 3)) begin bus.REQ = 1'b1; bus.TARGET = 1'b0; end
            tick();
            bus.REQ = 1'b0;
        end
        vectors++; if (bus.DONE !== 1'b1)  begin miscompares++; $display("FAIL %s_done got=%b exp=1", tag, bus.DONE); end
        vectors++; if (bus.VALID !== 1'b0) begin miscompares++; $display("FAIL %s_fin_valid got=%b exp=0", tag, bus.VALID); end
        vectors++; if (bus.COUNT !== 4'(n)) begin miscompares++; $display("FAIL %s_final_count got=%h exp=%h", tag, bus.COUNT, 4'(n)); end
        tick();
        vectors++; if (bus.DONE !== 1'b0) begin miscompares++; $display("FAIL %s_done_pulse got=%b exp=0", tag, bus.DONE); end
        vectors++; if (bus.BUSY !== 1'b0) begin miscompares++; $display("FAIL %s_idle_busy got=%b exp=0", tag, bus.BUSY); end
        tick();
        vectors++; if (bus.COUNT !== 4'(n)) begin miscompares++; $display("FAIL %s_count_hold got=%h exp=%h", tag, bus.COUNT, 4'(n)); end
    endtask

    // Cycle-exact timeline for TARGET=1, REQ accepted at edge k.
    task automatic test_timing();
        logic       exp_valid [0:7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_vec   [0:7] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4};
        int         waitc;
        bus.READY = 1'b1; bus.TARGET = 1'b1; bus.REQ = 1'b1;
        tick();
        bus.REQ = 1'b0;
        vectors++; if (bus.BUSY !== 1'b1 || bus.VALID !== 1'b0) begin miscompares++; $display("FAIL timing_k busy=%b valid=%b exp busy=1 valid=0", bus.BUSY, bus.VALID); end
        for (int c = 0; c < 8; c++) begin
            tick();
            vectors++; if (bus.VALID !== exp_valid[c]) begin miscompares++; $display("FAIL timing_valid edge=k+%0d got=%b exp=%b", c + 1, bus.VALID, exp_valid[c]); end
            vectors++; if (bus.VEC !== exp_vec[c]) begin miscompares++; $display("FAIL timing_vec edge=k+%0d got=%h exp=%h", c + 1, bus.VEC, exp_vec[c]); end
        end
        waitc = 0;
        while (bus.DONE !== 1'b1 && waitc < 20) begin tick(); waitc++; end
        vectors++; if (bus.DONE !== 1'b1) begin miscompares++; $display("FAIL timing_drain_timeout got=%b exp=1", bus.DONE); end
        tick();
    endtask

    // Stall the 0001 presentation for 3 cycles.
    task automatic test_backpressure();
        int waitc;
        bus.READY = 1'b1; bus.TARGET = 1'b1; bus.REQ = 1'b1;
        tick();
        bus.REQ = 1'b0;
        tick(); tick(); tick();
        bus.READY = 1'b0;
        vectors++; if (bus.VEC !== 4'h1 || bus.VALID !== 1'b1) begin miscompares++; $display("FAIL bp_present vec=%h valid=%b exp vec=1 valid=1", bus.VEC, bus.VALID); end
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++; if (bus.VEC !== 4'h1)   begin miscompares++; $display("FAIL bp_vec cyc=%0d got=%h exp=1", c, bus.VEC); end
            vectors++; if (bus.VALID !== 1'b1) begin miscompares++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", c, bus.VALID); end
            vectors++; if (bus.COUNT !== 4'h1) begin miscompares++; $display("FAIL bp_count cyc=%0d got=%h exp=1", c, bus.COUNT); end
        end
        bus.READY = 1'b1;
        tick();
        vectors++; if (bus.VALID !== 1'b0 || bus.BUSY !== 1'b1) begin miscompares++; $display("FAIL bp_release valid=%b busy=%b exp valid=0 busy=1", bus.VALID, bus.BUSY); end
        vectors++; if (bus.COUNT !== 4'h2) begin miscompares++; $display("FAIL bp_release_count got=%h exp=2", bus.COUNT); end
        waitc = 0;
        while (bus.DONE !== 1'b1 && waitc < 20) begin tick(); waitc++; end
        vectors++; if (bus.COUNT !== 4'h5 || bus.DONE !== 1'b1) begin miscompares++; $display("FAIL bp_final count=%h done=%b exp count=5 done=1", bus.COUNT, bus.DONE); end
        tick();
    endtask

    // Reset after two handshakes (with REQ concurrent), then restart.
    task automatic test_reset_midrun();
        int waitc;
        bus.READY = 1'b1; bus.TARGET = 1'b0; bus.REQ = 1'b1;
        tick();
        bus.REQ = 1'b0;
        waitc = 0;
        while (bus.COUNT !== 4'h2 && waitc < 20) begin tick(); waitc++; end
        vectors++; if (bus.COUNT !== 4'h2) begin miscompares++; $display("FAIL rstmid_reach got=%h exp=2", bus.COUNT); end
        rst = 1'b1; bus.REQ = 1'b1; bus.TARGET = 1'b1;
        tick();
        rst = 1'b0; bus.REQ = 1'b0;
        vectors++; if (bus.VEC !== 4'h0 || bus.VALID !== 1'b0 || bus.LAST !== 1'b0) begin miscompares++; $display("FAIL rstmid_out vec=%h valid=%b last=%b exp 0/0/0", bus.VEC, bus.VALID, bus.LAST); end
        vectors++; if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0 || bus.COUNT !== 4'h0) begin miscompares++; $display("FAIL rstmid_status busy=%b done=%b count=%h exp 0/0/0", bus.BUSY, bus.DONE, bus.COUNT); end
        tick();
        vectors++; if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle busy=%b done=%b exp 0/0", bus.BUSY, bus.DONE); end
        bus.TARGET = 1'b1; bus.REQ = 1'b1;
        tick();
        bus.REQ = 1'b0;
        vectors++; if (bus.BUSY !== 1'b1) begin miscompares++; $display("FAIL rstmid_restart_busy got=%b exp=1", bus.BUSY); end
        tick();
        vectors++; if (bus.VALID !== 1'b1 || bus.VEC !== 4'h0 || bus.COUNT !== 4'h0) begin miscompares++; $display("FAIL rstmid_restart valid=%b vec=%h count=%h exp 1/0/0", bus.VALID, bus.VEC, bus.COUNT); end
        waitc = 0;
        while (bus.DONE !== 1'b1 && waitc < 20) begin tick(); waitc++; end
        vectors++; if (bus.DONE !== 1'b1 || bus.COUNT !== 4'h5) begin miscompares++; $display("FAIL rstmid_drain done=%b count=%h exp 1/5", bus.DONE, bus.COUNT); end
        tick();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus.REQ = 1'b0; bus.TARGET = 1'b0; bus.READY = 1'b0;
        test_reset();
        test_run(1'b1, 5, 1'b0, "t1");
        test_run(1'b0, 11, 1'b0, "t0");
        test_timing();
        test_backpressure();
        test_run(1'b1, 5, 1'b1, "reqign");
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
